// File: rtl/and32_bist.sv
// Self-test engine for the 32-bit AND unit: drives operand pairs, waits a settle
// time, checks the returned result and keeps pass/fail statistics for the run.
module and32_bist #(
  parameter int unsigned NUM_RANDOM    = 16,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [31:0] SEED          = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] result_in,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  fail_count,
  output logic        first_fail_valid,
  output logic [7:0]  first_fail_index
);

  typedef enum logic [1:0] {IDLE, HOLD, CHECK, DONE} state_t;

  localparam int unsigned NUM_VECTORS = 4 + NUM_RANDOM;
  localparam logic [7:0]  LAST_INDEX  = 8'(NUM_VECTORS - 1);
  localparam logic [31:0] SEED_EFF    = (SEED == 32'd0) ? 32'h0000_0001 : SEED;
  localparam logic [3:0]  SETTLE_LAST = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);
  localparam state_t      LOAD_STATE  = (SETTLE_CYCLES == 0) ? CHECK : HOLD;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [3:0]  settle_q, settle_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [7:0]  fail_q, fail_d;
  logic        ffv_q, ffv_d;
  logic [7:0]  ffi_q, ffi_d;
  logic        done_q, done_d;

  logic [31:0] lfsr_a, lfsr_b;
  logic [7:0]  next_idx;
  logic        mismatch;

  assign lfsr_a   = lfsr_step(lfsr_q);
  assign lfsr_b   = lfsr_step(lfsr_a);
  assign next_idx = idx_q + 8'd1;
  assign mismatch = (result_in != (op_a_q & op_b_q));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      settle_q <= '0;
      lfsr_q   <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      fail_q   <= '0;
      ffv_q    <= 1'b0;
      ffi_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      lfsr_q   <= lfsr_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      fail_q   <= fail_d;
      ffv_q    <= ffv_d;
      ffi_q    <= ffi_d;
      done_q   <= done_d;
    end
  end

  // done rises one edge after DONE is entered, so the run ends on the edge after the last compare
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    lfsr_d   = lfsr_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    fail_d   = fail_q;
    ffv_d    = ffv_q;
    ffi_d    = ffi_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) done_d = 1'b1;
        if (start && (state_q == IDLE || done_q)) begin
          state_d  = LOAD_STATE;
          idx_d    = '0;
          settle_d = '0;
          lfsr_d   = SEED_EFF;
          op_a_d   = '0;
          op_b_d   = '0;
          fail_d   = '0;
          ffv_d    = 1'b0;
          ffi_d    = '0;
          done_d   = 1'b0;
        end
      end
      HOLD: begin
        if (settle_q == SETTLE_LAST) state_d = CHECK;
        else                         settle_d = settle_q + 4'd1;
      end
      CHECK: begin
        if (mismatch) begin
          if (fail_q != 8'hFF) fail_d = fail_q + 8'd1;
          if (!ffv_q) begin
            ffv_d = 1'b1;
            ffi_d = idx_q;
          end
        end
        if (idx_q == LAST_INDEX) begin
          state_d = DONE;
        end else begin
          state_d  = LOAD_STATE;
          idx_d    = next_idx;
          settle_d = '0;
          unique case (next_idx)
            8'd1:    begin op_a_d = 32'hAAAA_AAAA; op_b_d = 32'hAAAA_AAAA; end
            8'd2:    begin op_a_d = 32'hAAAA_AAAA; op_b_d = 32'h5555_5555; end
            8'd3:    begin op_a_d = 32'hFFFF_FFFF; op_b_d = 32'hFFFF_FFFF; end
            default: begin op_a_d = lfsr_a; op_b_d = lfsr_b; lfsr_d = lfsr_b; end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign op_a             = op_a_q;
  assign op_b             = op_b_q;
  assign busy             = (state_q != IDLE) && !done_q;
  assign done             = done_q;
  assign pass             = done_q && (fail_q == 8'd0);
  assign fail_count       = fail_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_index = ffi_q;

endmodule
